hamming_secded_pipe: RTL and testbench

// - Parametrised SEC-DED Hamming decoder: successor of the combinational (7,4) decoder and display.
// - Extended code (Hamming + overall parity) with a 2-stage valid/ready pipeline.
// - Saturating corrected/uncorrectable error counters.
// - Optional hex display of the last syndrome.
// - Sits between the serial-link receiver and the data consumer.

---
 rtl/hamming_secded_pipe.sv | 114 +++++++++++
 tb/tb_hamming_secded_pipe.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_secded_pipe.sv
// hamming_secded_pipe: SEC-DED extended Hamming decoder with 2-stage valid/ready pipeline and saturating error counters
// Ports: clk_i/rst_i (sync, active-high); valid_i/ready_o/palabra_i input handshake (bit0 = overall parity);
//   valid_o/ready_i output handshake with dato_o, sindrome_o, error_o (00 ok, 01 corrected, 10 double, 11 bit0 only);
//   clr_cnt_i clears corr_cnt_o/dbl_cnt_o; siete_seg_o active-low {g,f,e,d,c,b,a}.
// Define SIETE_SEG_EN to enable the registered hex display of the last syndrome; otherwise it is blank.
module hamming_secded_pipe #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8,
  localparam int P  = $clog2(DATA_W + $clog2(DATA_W + 1) + 1),
  localparam int N  = (1 << P) - 1,
  localparam int CW = N + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CW-1:0]     palabra_i,
  input  logic              clr_cnt_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] dato_o,
  output logic [P-1:0]      sindrome_o,
  output logic [1:0]        error_o,
  output logic [CNT_W-1:0]  corr_cnt_o,
  output logic [CNT_W-1:0]  dbl_cnt_o,
  output logic [6:0]        siete_seg_o
);
  // data bits sit at the non-power-of-two positions, ascending
  function automatic logic [DATA_W-1:0] extract(input logic [CW-1:0] w);
    logic [DATA_W-1:0] r;
    int k;
    r = '0;
    k = 0;
    for (int i = 1; i < CW; i++)
      if ((i & (i - 1)) != 0) begin
        r[k] = w[i];
        k++;
      end
    return r;
  endfunction
  logic              adv, xfer;
  logic              v1_q, v1_d, p1_q, p1_d;
  logic [CW-1:0]     w1_q, w1_d;
  logic [P-1:0]      s1_q, s1_d, sind_q, sind_d, syn;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] dato_q, dato_d;
  logic [1:0]        err_q, err_d, cls;
  logic [CNT_W-1:0]  corr_q, corr_d, dbl_q, dbl_d;
  logic [CW-1:0]     fixed;
  always_comb begin
    adv = !valid_q || ready_i;
    xfer = valid_q && ready_i;
    syn = '0;
    for (int i = 1; i < CW; i++) syn ^= palabra_i[i] ? P'(i) : '0;
    cls = (s1_q != '0) ? (p1_q ? 2'b01 : 2'b10) : (p1_q ? 2'b11 : 2'b00);
    fixed = (cls == 2'b01) ? w1_q ^ (CW'(1) << s1_q) : w1_q;
    v1_d = adv ? valid_i : v1_q;
    w1_d = adv ? palabra_i : w1_q;
    s1_d = adv ? syn : s1_q;
    p1_d = adv ? ^palabra_i : p1_q;
    valid_d = adv ? v1_q : valid_q;
    dato_d = (adv && v1_q) ? extract(fixed) : dato_q;
    sind_d = (adv && v1_q) ? s1_q : sind_q;
    err_d = (adv && v1_q) ? cls : err_q;
    corr_d = clr_cnt_i ? '0 : (xfer && err_q[0] && !(&corr_q)) ? corr_q + 1'b1 : corr_q;
    dbl_d = clr_cnt_i ? '0 : (xfer && err_q == 2'b10 && !(&dbl_q)) ? dbl_q + 1'b1 : dbl_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q <= 1'b0;
      w1_q <= '0;
      s1_q <= '0;
      p1_q <= 1'b0;
      valid_q <= 1'b0;
      dato_q <= '0;
      sind_q <= '0;
      err_q <= 2'b00;
      corr_q <= '0;
      dbl_q <= '0;
    end else begin
      v1_q <= v1_d;
      w1_q <= w1_d;
      s1_q <= s1_d;
      p1_q <= p1_d;
      valid_q <= valid_d;
      dato_q <= dato_d;
      sind_q <= sind_d;
      err_q <= err_d;
      corr_q <= corr_d;
      dbl_q <= dbl_d;
    end
  end
  assign ready_o = adv;
  assign valid_o = valid_q;
  assign dato_o = dato_q;
  assign sindrome_o = sind_q;
  assign error_o = err_q;
  assign corr_cnt_o = corr_q;
  assign dbl_cnt_o = dbl_q;
`ifdef SIETE_SEG_EN
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0]   seg_q, seg_d;
  logic [P+3:0] syn_x;
  always_comb begin
    syn_x = {4'b0, s1_q};
    seg_d = (adv && v1_q) ? ((cls == 2'b10) ? 7'h06 : HEX[syn_x[3:0]]) : seg_q;
  end
  always_ff @(posedge clk_i) seg_q <= rst_i ? 7'h7F : seg_d;
  assign siete_seg_o = seg_q;
`else
  assign siete_seg_o = 7'h7F;
`endif
endmodule

// File: tb/tb_hamming_secded_pipe.sv
// tb_hamming_secded_pipe: directed and randomized checks of hamming_secded_pipe (DATA_W=4) against a flip-based reference model
module tb_hamming_secded_pipe;
  logic       clk, rst_i, valid_i, ready_i, clr_cnt_i;
  logic [7:0] palabra_i;
  logic       ready_o, valid_o, b_ready_o, b_valid_o;
  logic [3:0] dato_o, b_dato_o;
  logic [2:0] sindrome_o, b_sindrome_o;
  logic [1:0] error_o, b_error_o;
  logic [7:0] corr_cnt_o, dbl_cnt_o;
  logic [1:0] b_corr_cnt_o, b_dbl_cnt_o;
  logic [6:0] siete_seg_o, b_siete_seg_o;
  int errors = 0;
  int checks = 0;
  hamming_secded_pipe #(.DATA_W(4), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .palabra_i(palabra_i),
    .clr_cnt_i(clr_cnt_i), .valid_o(valid_o), .ready_i(ready_i), .dato_o(dato_o),
    .sindrome_o(sindrome_o), .error_o(error_o), .corr_cnt_o(corr_cnt_o), .dbl_cnt_o(dbl_cnt_o),
    .siete_seg_o(siete_seg_o));
  hamming_secded_pipe #(.DATA_W(4), .CNT_W(2)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(b_ready_o), .palabra_i(palabra_i),
    .clr_cnt_i(clr_cnt_i), .valid_o(b_valid_o), .ready_i(ready_i), .dato_o(b_dato_o),
    .sindrome_o(b_sindrome_o), .error_o(b_error_o), .corr_cnt_o(b_corr_cnt_o), .dbl_cnt_o(b_dbl_cnt_o),
    .siete_seg_o(b_siete_seg_o));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  typedef struct packed {
    logic [3:0] d;
    logic [2:0] s;
    logic [1:0] e;
  } exp_t;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] w;
    w = '0;
    w[3] = d[0];
    w[5] = d[1];
    w[6] = d[2];
    w[7] = d[3];
    w[1] = w[3] ^ w[5] ^ w[7];
    w[2] = w[3] ^ w[6] ^ w[7];
    w[4] = w[5] ^ w[6] ^ w[7];
    w[0] = ^w[7:1];
    return w;
  endfunction
  function automatic logic [6:0] seg_of(input logic [1:0] e, input logic [2:0] s);
    logic [6:0] hex [8];
    hex = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
`ifdef SIETE_SEG_EN
    return (e == 2'b10) ? 7'h06 : hex[s];
`else
    return (e == 2'b10 || s > 3'd7) ? 7'h7F : 7'h7F;
`endif
  endfunction
  task automatic send(input logic [7:0] w, input logic [3:0] ed, input logic [2:0] es, input logic [1:0] ee, input string tag);
    valid_i = 1'b1;
    palabra_i = w;
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk({tag, "_lat1_valid"}, valid_o, 0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, valid_o, 1);
    chk({tag, "_dato"}, dato_o, ed);
    chk({tag, "_sind"}, sindrome_o, es);
    chk({tag, "_err"}, error_o, ee);
    chk({tag, "_seg"}, siete_seg_o, seg_of(ee, es));
    @(posedge clk); #1;
  endtask
  exp_t q[$];
  exp_t x, f;
  int m_corr, m_dbl, mb_corr, mb_dbl;
  initial begin
    logic [7:0] w;
    logic [3:0] d;
    int nf, pa, pb;
    bit drain;
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; clr_cnt_i = 1'b0; palabra_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    chk("rst_valid", valid_o, 0);
    chk("rst_dato", dato_o, 0);
    chk("rst_sind", sindrome_o, 0);
    chk("rst_err", error_o, 0);
    chk("rst_corr", corr_cnt_o, 0);
    chk("rst_dbl", dbl_cnt_o, 0);
    chk("rst_seg", siete_seg_o, 7'h7F);
    chk("rst_ready", ready_o, 1);
    send(8'hAA, 4'hB, 3'd0, 2'b00, "clean");
    chk("clean_corr", corr_cnt_o, 0);
    chk("clean_dbl", dbl_cnt_o, 0);
    send(8'h8A, 4'hB, 3'd5, 2'b01, "single5");
    chk("single5_corr", corr_cnt_o, 1);
    send(8'hAB, 4'hB, 3'd0, 2'b11, "bit0");
    chk("bit0_corr", corr_cnt_o, 2);
    send(8'hAC, 4'hB, 3'd3, 2'b10, "double");
    chk("double_dbl", dbl_cnt_o, 1);
    chk("double_corr", corr_cnt_o, 2);
    ready_i = 1'b0; valid_i = 1'b1; palabra_i = 8'h8A;
    #1 chk("bp_rdy0", ready_o, 1);
    @(posedge clk); #1;
    palabra_i = 8'hAA;
    chk("bp_rdy1", ready_o, 1);
    @(posedge clk); #1;
    palabra_i = 8'hAC;
    chk("bp_rdy2", ready_o, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_rdy", ready_o, 0);
      chk("bp_hold_valid", valid_o, 1);
      chk("bp_hold_dato", dato_o, 4'hB);
      chk("bp_hold_sind", sindrome_o, 5);
      chk("bp_hold_err", error_o, 2'b01);
      chk("bp_hold_corr", corr_cnt_o, 2);
    end
    ready_i = 1'b1;
    #1 chk("bp_release_rdy", ready_o, 1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk("bp_w2_valid", valid_o, 1);
    chk("bp_w2_sind", sindrome_o, 0);
    chk("bp_w2_err", error_o, 2'b00);
    chk("bp_w1_corr", corr_cnt_o, 3);
    @(posedge clk); #1;
    chk("bp_w3_valid", valid_o, 1);
    chk("bp_w3_sind", sindrome_o, 3);
    chk("bp_w3_err", error_o, 2'b10);
    chk("bp_w3_dato", dato_o, 4'hB);
    chk("bp_w3_seg", siete_seg_o, seg_of(2'b10, 3'd3));
    @(posedge clk); #1;
    chk("bp_done_valid", valid_o, 0);
    chk("bp_dbl", dbl_cnt_o, 2);
    chk("bp_corr_once", corr_cnt_o, 3);
    chk("b_corr_sat3", b_corr_cnt_o, 3);
    chk("b_dbl", b_dbl_cnt_o, 2);
    send(8'h8A, 4'hB, 3'd5, 2'b01, "more1");
    send(8'h8A, 4'hB, 3'd5, 2'b01, "more2");
    chk("more_corr", corr_cnt_o, 5);
    chk("b_corr_saturated", b_corr_cnt_o, 3);
    valid_i = 1'b1; palabra_i = 8'h8A;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(posedge clk); #1;
    chk("clr_xfer_valid", valid_o, 1);
    clr_cnt_i = 1'b1;
    @(posedge clk); #1;
    clr_cnt_i = 1'b0;
    chk("clr_corr", corr_cnt_o, 0);
    chk("clr_dbl", dbl_cnt_o, 0);
    chk("clr_b_corr", b_corr_cnt_o, 0);
    chk("clr_b_dbl", b_dbl_cnt_o, 0);
    valid_i = 1'b1; palabra_i = 8'hAB;
    @(posedge clk); #1;
    palabra_i = 8'hAC;
    @(posedge clk); #1;
    chk("mid_rst_pre_valid", valid_o, 1);
    rst_i = 1'b1; valid_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_err", error_o, 0);
    chk("mid_rst_dato", dato_o, 0);
    chk("mid_rst_seg", siete_seg_o, 7'h7F);
    @(posedge clk); #1;
    chk("mid_rst_dropped", valid_o, 0);
    @(posedge clk); #1;
    chk("mid_rst_corr", corr_cnt_o, 0);
    chk("mid_rst_dbl", dbl_cnt_o, 0);
    m_corr = 0; m_dbl = 0; mb_corr = 0; mb_dbl = 0;
    for (int it = 0; it < 400; it++) begin
      chk("rnd_corr", corr_cnt_o, m_corr);
      chk("rnd_dbl", dbl_cnt_o, m_dbl);
      chk("rnd_b_corr", b_corr_cnt_o, mb_corr);
      chk("rnd_b_dbl", b_dbl_cnt_o, mb_dbl);
      if (valid_o) begin
        chk("rnd_q_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          f = q[0];
          chk("rnd_dato", dato_o, f.d);
          chk("rnd_sind", sindrome_o, f.s);
          chk("rnd_err", error_o, f.e);
          chk("rnd_seg", siete_seg_o, seg_of(f.e, f.s));
        end
      end
      drain = it >= 390;
      ready_i = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
      valid_i = drain ? 1'b0 : 1'($urandom_range(0, 1));
      clr_cnt_i = drain ? 1'b0 : ($urandom_range(0, 39) == 0);
      d = 4'($urandom_range(0, 15));
      nf = $urandom_range(0, 2);
      pa = $urandom_range(0, 7);
      pb = (pa + $urandom_range(1, 7)) % 8;
      w = encode(d);
      if (nf >= 1) w[pa] = ~w[pa];
      if (nf == 2) w[pb] = ~w[pb];
      x.d = (nf == 2) ? {w[7], w[6], w[5], w[3]} : d;
      x.s = (nf == 0) ? 3'd0 : (nf == 1) ? 3'(pa) : 3'(pa ^ pb);
      x.e = (nf == 0) ? 2'b00 : (nf == 2) ? 2'b10 : (pa == 0) ? 2'b11 : 2'b01;
      palabra_i = w;
      #1;
      if (valid_o && ready_i && q.size() != 0) begin
        f = q.pop_front();
        if (f.e == 2'b01 || f.e == 2'b11) begin
          if (m_corr < 255) m_corr++;
          if (mb_corr < 3) mb_corr++;
        end
        if (f.e == 2'b10) begin
          if (m_dbl < 255) m_dbl++;
          if (mb_dbl < 3) mb_dbl++;
        end
      end
      if (clr_cnt_i) begin
        m_corr = 0; m_dbl = 0; mb_corr = 0; mb_dbl = 0;
      end
      if (valid_i && ready_o) q.push_back(x);
      @(posedge clk); #1;
    end
    chk("rnd_drained_q", q.size(), 0);
    chk("rnd_drained_valid", valid_o, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
